// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU datapath blocks.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } sa_state_t;

    // Accumulator width that holds an n-term sum of dw x dw products without wrap.
    function automatic int sa_acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: multiply-accumulate with a one-stage
// operand pipe passing A to the right and B downward.
module systolic_pe #(
    parameter int DW     = 8,
    parameter int AW     = 19,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic signed [2*DW-1:0] aExt, bExt;
    logic        [2*DW-1:0] prod;
    logic        [AW-1:0]   prodExt;
    logic        [AW-1:0]   acc_d, acc_q;
    logic        [DW-1:0]   a_q, b_q;

    // Extending both operands to 2*DW first keeps one multiplier for both modes.
    always_comb begin
        aExt    = (SIGNED != 0) ? {{DW{a_in[DW-1]}}, a_in} : {{DW{1'b0}}, a_in};
        bExt    = (SIGNED != 0) ? {{DW{b_in[DW-1]}}, b_in} : {{DW{1'b0}}, b_in};
        prod    = aExt * bExt;
        prodExt = (SIGNED != 0) ? {{(AW-2*DW){prod[2*DW-1]}}, prod}
                                : {{(AW-2*DW){1'b0}}, prod};
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prodExt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= en ? a_in : '0;
            b_q   <= en ? b_in : '0;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_array.sv
// N x N output-stationary systolic matrix multiplier with start/busy/done
// handshake; computes C = A * B at full precision.
module systolic_array
    import tpu_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    parameter int AW     = sa_acc_w(DW, N)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N-1:0][N-1:0][DW-1:0]  a,
    input  logic [N-1:0][N-1:0][DW-1:0]  b,
    output logic [N-1:0][N-1:0][AW-1:0]  c,
    output logic                         busy,
    output logic                         done
);

    localparam int            TW     = $clog2(3 * N);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    sa_state_t                       state_q;
    logic [TW-1:0]                   t_q;
    logic [N-1:0][N-1:0][DW-1:0]     aOp_q, bOp_q;
    logic [N-1:0][N-1:0][AW-1:0]     c_q;
    logic                            busy_q, done_q;

    logic                            accept, feedEn;
    logic [N-1:0][DW-1:0]            leftIn, topIn;
    logic [N-1:0][N-1:0][DW-1:0]     aWire, bWire;
    logic [N-1:0][N-1:0][AW-1:0]     accs;
    logic [N-1:0][DW-1:0]            unusedATail, unusedBTail;

    assign accept = (state_q == IDLE) && start;
    assign feedEn = (state_q == FEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            aOp_q   <= '0;
            bOp_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FEED;
                        busy_q  <= 1'b1;
                        aOp_q   <= a;
                        bOp_q   <= b;
                        t_q     <= '0;
                    end
                end
                FEED: begin
                    if (t_q == T_LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                DRAIN: begin
                    c_q     <= accs;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Skewed injection: row i sees A[i][t-i], column j sees B[t-j][j], else zero.
    always_comb begin
        leftIn = '0;
        topIn  = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t_q) == i + k) begin
                    leftIn[i] = aOp_q[i][k];
                    topIn[i]  = bOp_q[k][i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign aWire[gi][0] = leftIn[gi];
        assign bWire[0][gi] = topIn[gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0] aOut, bOut;

            systolic_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (feedEn),
                .clr   (accept),
                .a_in  (aWire[gi][gj]),
                .b_in  (bWire[gi][gj]),
                .a_out (aOut),
                .b_out (bOut),
                .acc   (accs[gi][gj])
            );

            if (gj < N - 1) begin : g_a_link
                assign aWire[gi][gj+1] = aOut;
            end else begin : g_a_tail
                assign unusedATail[gi] = aOut;
            end
            if (gi < N - 1) begin : g_b_link
                assign bWire[gi+1][gj] = bOut;
            end else begin : g_b_tail
                assign unusedBTail[gj] = bOut;
            end
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/systolic_array.md
# systolic_array

Parametrised N×N output-stationary systolic matrix multiplier; the generalised successor to the fixed 2×2 array in the TPU datapath. On `start` it captures two N×N operand matrices, injects them into the PE grid with row and column skew, accumulates at full precision, and publishes C = A·B with a one-cycle `done` pulse. It adds an explicit busy/done handshake, signed/unsigned mode and a per-run accumulator clear.

## Interface
- `N`, 4: array dimension, N ≥ 2.
- `DW`, 8: operand element width.
- `SIGNED`, 0: 1 = two's-complement operands and results, 0 = unsigned.
- `AW`, 2*DW+$clog2(N): accumulator/result width. It is derived; do not override.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a run. Sampled only in IDLE.
- `a`  in  [N][N]×DW  operand A[row][col].
- `b`  in  [N][N]×DW  operand B[row][col].
- `c`  out  [N][N]×AW  result C[row][col]. Registered; holds until the next run completes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `c` updates.

## Operation
- **FSM states:** IDLE → FEED → DRAIN → IDLE.
  - IDLE & `start` → FEED. On that edge (E0): latch `a`/`b` into operand registers, clear all accumulators, step counter t := 0.
  - FEED lasts 3N−2 cycles (t = 0..3N−3). Leave FEED when t = 3N−3.
  - DRAIN lasts 1 cycle. At its closing edge: `c` ← accumulators, `done` ← 1, state → IDLE.
- **Edge injection during FEED step t:**
  - Row i left edge = A[i][t−i] if 0 ≤ t−i < N, else 0.
  - Column j top edge = B[t−j][j] if 0 ≤ t−j < N, else 0.
- **PE(i,j) on each FEED edge:**
  - acc += a_in × b_in.
  - Register a_in to the right neighbour and b_in to the lower neighbour.
  - Operand pipes are zeroed outside FEED, so no stray products accumulate.
- **Alignment:** PE(i,j) receives A[i][k] and B[k][j] together at step i+j+k. The last product lands at t = 3N−3.
- **Arithmetic:**
  - Products are 2·DW wide, sign- or zero-extended to AW per `SIGNED`.
  - The N-term sum always fits in AW, so no saturation or wrap is required or permitted.
- **Boundary conditions:**
  - `start` while busy: ignored, no queuing.
  - `a`/`b` changes after E0: no effect on the current run.
  - `start` held high continuously: a new run is accepted on the first IDLE edge after `done`.
  - Reset mid-run (`rst_n` low in any state): abort immediately; no `done`, `c` returns to 0.

## Timing
- **Reset values:**
  - State IDLE, `busy`=0, `done`=0.
  - Every `c` element, accumulator and pipe register = 0.
- **Latency:**
  - `done` and the new `c` appear on edge E(3N−1), counting from accept edge E0 (E5 for N=2, E11 for N=4).
  - `busy` rises at E0 and falls at E(3N−1), together with `done` rising.
- **Throughput:** one run per 3N cycles under back-to-back `start`.
- `done` is high for exactly one cycle. `c` is stable from E(3N−1) until the next run's DRAIN edge.

## Structure
- Package `tpu_pkg`:
  - `sa_state_t` enum (IDLE, FEED, DRAIN).
  - Function `sa_acc_w(dw, n)` returning 2*dw+$clog2(n).
- Sub-module `systolic_pe`, parametrised on DW, AW, SIGNED:
  - Ports: `clk`, `rst_n`, `en`, `clr`, `a_in`, `b_in`, `a_out`, `b_out`, `acc`.
  - `en` = FEED; `clr` = accept edge.
- Top level contains: FSM, step counter ($clog2(3N) bits), operand registers, skew muxes, generate-built N×N PE grid, `c` register.

## Test plan
- **Basic product:** N=2, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], `start` 1 cycle → `busy` rises at E0, `done` pulses at E5, `c`=[[19,22],[43,50]].
- **Unsigned maximum:** N=4, unsigned, all elements 255 → every `c` = 260100, no overflow at AW=18.
- **Signed mode:** N=2, SIGNED=1, A=[[−1,2],[3,−4]], B=[[−128,0],[0,−128]] → `c`=[[128,−256],[−384,512]]. Separately, all elements −128 → each `c` = 32768.
- **Start while busy / input change:** assert `start` mid-FEED with different `a` → ignored, first result unchanged. Change `a` after E0 → no effect on that run.
- **Back-to-back:** N=2, `start` held high for two runs (identity·B, then A·identity) → `done` at E5 and E11, each `c` correct, no cross-run accumulation.
- **Reset mid-run:** N=3, drop `rst_n` at t=4 → `busy`, `done`, `c` all 0 immediately, state IDLE. A subsequent run gives a correct result.
